seq_detect_ctrl: RTL and testbench

//  Controller that feeds a serial pattern detector from a parallel word stream.
//  - Accepts DATA_W-bit words over a valid/ready handshake and shifts each word MSB-first.
//  - Shifts into an overlapping PAT_W-bit pattern matcher (default pattern 1011).
//  - Counts matches and flags when a programmed threshold is reached.
//  - Sits between a byte-wide source (UART RX, FIFO) and status/interrupt logic.

---
 rtl/seq_detect_pkg.sv | 19 +
 rtl/seq_detect_core.sv | 63 ++++++
 rtl/seq_detect_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern-detect controller.
// Imported by seq_detect_core and seq_detect_ctrl.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Width of an index/counter able to address n positions (minimum 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Overlapping serial pattern matcher: PAT_W-bit history, fill counter and comparator.
// 'hit' flags the match produced by the bit being shifted this cycle; 'match' is its registered pulse.
module seq_detect_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    output logic             match,
    output logic             hit
);

    localparam int FILL_W = idx_width(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_r;
    logic [PAT_W-1:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nxt_s;
    logic              match_r;

    // Next history/fill values; a match needs a full window, so early bits cannot alias the pattern.
    always_comb begin
        hist_nxt_s = {hist_r[PAT_W-2:0], bit_in};
        fill_nxt_s = fill_r;
        if (fill_r == FILL_FULL) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + FILL_W'(1'b1);
        end
        hit = bit_en && (hist_nxt_s == pattern) && (fill_nxt_s == FILL_FULL);
    end

    // History, fill count and registered match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r  <= {PAT_W{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            match_r <= 1'b0;
        end else if (clear) begin
            hist_r  <= {PAT_W{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            match_r <= 1'b0;
        end else begin
            match_r <= hit;
            if (bit_en) begin
                hist_r <= hist_nxt_s;
                fill_r <= fill_nxt_s;
            end else begin
                hist_r <= hist_r;
                fill_r <= fill_r;
            end
        end
    end

    assign match = match_r;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Session controller: accepts parallel words, serialises them MSB-first into the matcher,
// counts matches against a latched threshold and signals session completion.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              thresh_hit,
    output logic              done
);

    localparam int IDX_W = idx_width(DATA_W);

    state_t             state_r;
    state_t             state_fsm_s;
    state_t             state_nxt_s;
    logic               start_s;
    logic               accept_s;
    logic               shift_s;
    logic               hit_s;
    logic               bit_s;

    logic [DATA_W-1:0]  word_r;
    logic [IDX_W-1:0]   bit_idx_r;
    logic               last_r;
    logic [PAT_W-1:0]   pattern_r;
    logic [CNT_W-1:0]   thresh_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               cnt_sat_s;
    logic               thresh_hit_r;
    logic               s_ready_r;
    logic               busy_r;
    logic               done_r;

    // Next-state and control strobes; abort overrides every transition.
    always_comb begin
        state_fsm_s = state_r;
        start_s     = 1'b0;
        accept_s    = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    start_s     = 1'b1;
                    state_fsm_s = ST_ACCEPT;
                end else begin
                    state_fsm_s = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (s_valid) begin
                    accept_s    = 1'b1;
                    state_fsm_s = ST_SHIFT;
                end else begin
                    state_fsm_s = ST_ACCEPT;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (bit_idx_r == {IDX_W{1'b0}}) begin
                    if (last_r) begin
                        state_fsm_s = ST_DONE;
                    end else begin
                        state_fsm_s = ST_ACCEPT;
                    end
                end else begin
                    state_fsm_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_fsm_s = ST_IDLE;
            end
            default: begin
                state_fsm_s = ST_IDLE;
            end
        endcase
        state_nxt_s = abort ? ST_IDLE : state_fsm_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Session configuration, captured only when a session starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_r <= {PAT_W{1'b0}};
            thresh_r  <= {CNT_W{1'b0}};
        end else if (start_s) begin
            pattern_r <= cfg_pattern;
            thresh_r  <= cfg_thresh;
        end else begin
            pattern_r <= pattern_r;
            thresh_r  <= thresh_r;
        end
    end

    // Word holding register and MSB-first bit pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r    <= {DATA_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            last_r    <= 1'b0;
        end else if (accept_s) begin
            word_r    <= s_data;
            bit_idx_r <= IDX_W'(DATA_W - 1);
            last_r    <= s_last;
        end else if (shift_s) begin
            word_r    <= word_r;
            bit_idx_r <= bit_idx_r - IDX_W'(1'b1);
            last_r    <= last_r;
        end else begin
            word_r    <= word_r;
            bit_idx_r <= bit_idx_r;
            last_r    <= last_r;
        end
    end

    assign bit_s = word_r[bit_idx_r];

    seq_detect_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_in  (bit_s),
        .bit_en  (shift_s),
        .clear   (start_s),
        .pattern (pattern_r),
        .match   (match_pulse),
        .hit     (hit_s)
    );

    always_comb begin
        cnt_sat_s = &cnt_r;
        cnt_inc_s = cnt_r + CNT_W'(1'b1);
    end

    // Match counter and sticky threshold flag update on the same edge as the match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= {CNT_W{1'b0}};
            thresh_hit_r <= 1'b0;
        end else if (start_s) begin
            cnt_r        <= {CNT_W{1'b0}};
            thresh_hit_r <= 1'b0;
        end else if (hit_s && !cnt_sat_s) begin
            cnt_r        <= cnt_inc_s;
            thresh_hit_r <= thresh_hit_r ||
                            ((thresh_r != {CNT_W{1'b0}}) && (cnt_inc_s == thresh_r));
        end else begin
            cnt_r        <= cnt_r;
            thresh_hit_r <= thresh_hit_r;
        end
    end

    // Status outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            s_ready_r <= (state_nxt_s == ST_ACCEPT);
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    assign s_ready    = s_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign match_cnt  = cnt_r;
    assign thresh_hit = thresh_hit_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a bit-stream reference model checked every cycle,
// plus directed sessions with hand-computed match counts and pulse positions.
module tb_seq_detect_ctrl;
    import seq_detect_pkg::*;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [PAT_W-1:0]  cfg_pattern = '0;
    logic [CNT_W-1:0]  cfg_thresh = '0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              busy;
    logic              match_pulse;
    logic [CNT_W-1:0]  match_cnt;
    logic              thresh_hit;
    logic              done;

    seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_thresh(cfg_thresh),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .busy(busy), .match_pulse(match_pulse), .match_cnt(match_cnt),
        .thresh_hit(thresh_hit), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is a queue of pending bits plus the recent bit history.
    bit             m_sess = 1'b0, m_ready = 1'b0, m_done = 1'b0, m_pulse = 1'b0;
    bit             m_hit = 1'b0, m_last = 1'b0, m_acc = 1'b0, m_new_pulse = 1'b0;
    bit             m_b = 1'b0, m_eq = 1'b0;
    int             m_cnt = 0, m_thr = 0, k_since = 0;
    logic [PAT_W-1:0] m_pat = '0;
    bit             pend[$];
    bit             hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sess = 0; m_ready = 0; m_done = 0; m_pulse = 0; m_hit = 0; m_last = 0;
            m_acc = 0; m_cnt = 0; m_thr = 0; m_pat = '0; k_since = 0;
            pend.delete(); hist.delete();
        end else begin
            m_new_pulse = 0;
            m_acc = 0;
            if (!m_sess) begin
                if (start && !abort) begin
                    m_pat = cfg_pattern; m_thr = cfg_thresh; m_cnt = 0; m_hit = 0;
                    hist.delete(); m_sess = 1; m_ready = 1;
                end
            end else if (m_done) begin
                m_done = 0; m_sess = 0;
            end else if (m_ready) begin
                if (s_valid) begin
                    for (int i = DATA_W - 1; i >= 0; i--) pend.push_back(s_data[i]);
                    m_last = s_last; m_ready = 0; m_acc = 1;
                end
            end else begin
                m_b = pend.pop_front();
                hist.push_back(m_b);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                if (hist.size() == PAT_W) begin
                    m_eq = 1;
                    for (int i = 0; i < PAT_W; i++)
                        if (hist[i] != m_pat[PAT_W-1-i]) m_eq = 0;
                    if (m_eq) begin
                        m_new_pulse = 1;
                        if (m_cnt < CNT_MAX) begin
                            m_cnt++;
                            if (m_thr != 0 && m_cnt == m_thr) m_hit = 1;
                        end
                    end
                end
                if (pend.size() == 0) begin
                    if (m_last) m_done = 1;
                    else m_ready = 1;
                end
            end
            if (abort) begin
                m_sess = 0; m_ready = 0; m_done = 0; pend.delete();
            end
            m_pulse = m_new_pulse;
            k_since = m_acc ? 0 : k_since + 1;
        end
    end

    // Per-cycle comparison against the model, plus event logs for the directed checks.
    int pulse_pos[$];
    int done_pos = -1;
    int done_seen = 0;
    logic hit_at_done = 1'b0;

    always @(negedge clk) begin
        chk("s_ready", s_ready, m_ready);
        chk("busy", busy, m_sess);
        chk("match_pulse", match_pulse, m_pulse);
        chk("match_cnt", match_cnt, m_cnt);
        chk("thresh_hit", thresh_hit, m_hit);
        chk("done", done, m_done);
        if (match_pulse === 1'b1) pulse_pos.push_back(k_since);
        if (done === 1'b1) begin
            done_pos = k_since;
            hit_at_done = thresh_hit;
            done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
        cfg_pattern = p;
        cfg_thresh  = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_pos.delete();
        done_pos  = -1;
        done_seen = 0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
        int  n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!rdy && n < 100) begin
            rdy = s_ready;
            tick();
            n++;
        end
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        chk("accept_in_time", rdy, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("idle_in_time", busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_cnt", match_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Single word B6 with the default pattern: matches after bits 4 and 7.
        do_start(DEFAULT_PATTERN, 8'd0);
        send_word(8'hB6, 1'b1);
        wait_idle();
        chk("b6_cnt", match_cnt, 2);
        chk("b6_npulse", pulse_pos.size(), 2);
        if (pulse_pos.size() == 2) begin
            chk("b6_pos0", pulse_pos[0], 4);
            chk("b6_pos1", pulse_pos[1], 7);
        end
        chk("b6_done_pos", done_pos, 8);
        chk("b6_done_once", done_seen, 1);
        chk("b6_no_thresh", thresh_hit, 1'b0);

        // Pattern straddling the word boundary.
        do_start(4'b1011, 8'd0);
        send_word(8'h05, 1'b0);
        send_word(8'h80, 1'b1);
        wait_idle();
        chk("xw_cnt", match_cnt, 1);
        chk("xw_npulse", pulse_pos.size(), 1);
        if (pulse_pos.size() == 1) chk("xw_pos", pulse_pos[0], 1);

        // Threshold of 3 reached by the final bit of the second word.
        do_start(4'b1011, 8'd3);
        send_word(8'hBB, 1'b0);
        send_word(8'h0B, 1'b1);
        chk("th_cnt_w1", match_cnt, 2);
        chk("th_hit_w1", thresh_hit, 1'b0);
        wait_idle();
        chk("th_cnt_w2", match_cnt, 3);
        chk("th_hit_at_done", hit_at_done, 1'b1);
        chk("th_hit_sticky", thresh_hit, 1'b1);

        // All-zero pattern: fill guard suppresses the first three bits.
        do_start(4'b0000, 8'd0);
        send_word(8'h00, 1'b1);
        wait_idle();
        chk("fill_cnt", match_cnt, 5);
        chk("fill_npulse", pulse_pos.size(), 5);

        // Stall in ACCEPT with a stray start, then abort mid-word.
        do_start(4'b1011, 8'd0);
        cfg_pattern = 4'b0000;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", s_ready, 1'b1);
            chk("stall_busy", busy, 1'b1);
        end
        start = 1'b0;
        send_word(8'hB6, 1'b0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_cnt", match_cnt, 1);
        tick();
        chk("abort_no_done", done_seen, 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 1'b0);
        chk("sa_cnt_kept", match_cnt, 1);

        // Asynchronous reset in the middle of a word.
        do_start(4'b1111, 8'd1);
        send_word(8'hFF, 1'b1);
        repeat (5) tick();
        chk("pre_rst_cnt", match_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ready", s_ready, 1'b0);
        chk("mrst_cnt", match_cnt, 0);
        chk("mrst_hit", thresh_hit, 1'b0);
        chk("mrst_pulse", match_pulse, 1'b0);
        chk("mrst_done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_ready", s_ready, 1'b0);
        chk("rel_busy", busy, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
